// File: rtl/l2_burst_adapter_if.sv
// Bus bundle for l2_burst_adapter: cache request side, L2 data-array write port and memory burst port.
// The adapter is the slave; the cache/memory environment drives the master side.
interface l2_burst_adapter_if #(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX  = 3,
   parameter int BEAT_W   = 64
);
   localparam int LINE_W = 8 * (2 ** S_OFFSET);
   localparam int MASK_W = 2 ** S_OFFSET;

   logic              fill_req;
   logic              wb_req;
   logic [31:0]       fill_addr;
   logic [31:0]       wb_addr;
   logic [LINE_W-1:0] wb_line;
   logic              done;
   logic [MASK_W-1:0] arr_we;
   logic [S_INDEX-1:0] arr_windex;
   logic [LINE_W-1:0] arr_datain;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [BEAT_W-1:0] mem_wdata;
   logic [BEAT_W-1:0] mem_rdata;
   logic              mem_resp;

   // Handshake: a request is held until the one-cycle done pulse; a memory beat
   // transfers in any cycle where mem_read|mem_write is high and mem_resp is high.
   modport slave (
      input  fill_req, wb_req, fill_addr, wb_addr, wb_line, mem_rdata, mem_resp,
      output done, arr_we, arr_windex, arr_datain, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output fill_req, wb_req, fill_addr, wb_addr, wb_line, mem_rdata, mem_resp,
      input  done, arr_we, arr_windex, arr_datain, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/l2_burst_adapter.sv
// Line-to-burst adapter between the L2 controller/data array and memory: writeback bursts,
// fill bursts assembled into one full-line array write. Optional counters under L2_BURST_PERF_EN.
module l2_burst_adapter #(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX  = 3,
   parameter int BEAT_W   = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   l2_burst_adapter_if.slave  bus,
`ifdef L2_BURST_PERF_EN
   output logic [31:0]        perf_fills,
   output logic [31:0]        perf_wbs,
`endif
   output logic [2:0]         dbg_state_o
);
   localparam int LINE_W = 8 * (2 ** S_OFFSET);
   localparam int MASK_W = 2 ** S_OFFSET;
   localparam int BEATS  = LINE_W / BEAT_W;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TAG_W  = 32 - S_OFFSET;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, WB, RD, COMMIT, DONE} state_t;

   state_t                         state_q;
   logic [CNT_W-1:0]               beat_cnt_q;
   logic [BEATS-1:0][BEAT_W-1:0]   line_q;
   logic [TAG_W-1:0]               fill_tag_q;
   logic                           fill_pend_q;
   logic                           done_q;
   logic [MASK_W-1:0]              arr_we_q;
   logic [S_INDEX-1:0]             arr_windex_q;
   logic                           mem_read_q;
   logic                           mem_write_q;
   logic [31:0]                    mem_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         line_q       <= '0;
         fill_tag_q   <= '0;
         fill_pend_q  <= 1'b0;
         done_q       <= 1'b0;
         arr_we_q     <= '0;
         arr_windex_q <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         done_q   <= 1'b0;
         arr_we_q <= '0;
         case (state_q)
            IDLE: begin
               if (bus.fill_req | bus.wb_req) begin
                  fill_tag_q  <= bus.fill_addr[31:S_OFFSET];
                  fill_pend_q <= bus.fill_req;
                  line_q      <= bus.wb_line;
                  beat_cnt_q  <= '0;
                  if (bus.wb_req) begin
                     state_q     <= WB;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= {bus.wb_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                  end else begin
                     state_q    <= RD;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= {bus.fill_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                  end
               end
            end
            WB: begin
               if (bus.mem_resp) begin
                  if (beat_cnt_q == LAST) begin
                     beat_cnt_q  <= '0;
                     mem_write_q <= 1'b0;
                     // Read burst starts on the very next cycle so the two strobes never overlap.
                     if (fill_pend_q) begin
                        state_q    <= RD;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= {fill_tag_q, {S_OFFSET{1'b0}}};
                     end else begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        mem_addr_q <= '0;
                     end
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            RD: begin
               if (bus.mem_resp) begin
                  line_q[beat_cnt_q] <= bus.mem_rdata;
                  if (beat_cnt_q == LAST) begin
                     beat_cnt_q   <= '0;
                     mem_read_q   <= 1'b0;
                     mem_addr_q   <= '0;
                     state_q      <= COMMIT;
                     arr_we_q     <= '1;
                     arr_windex_q <= fill_tag_q[S_INDEX-1:0];
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            COMMIT: begin
               state_q      <= DONE;
               done_q       <= 1'b1;
               arr_windex_q <= '0;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef L2_BURST_PERF_EN
   logic [31:0] perf_fills_q;
   logic [31:0] perf_wbs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fills_q <= '0;
         perf_wbs_q   <= '0;
      end else begin
         if (state_q == COMMIT) perf_fills_q <= perf_fills_q + 32'd1;
         if (state_q == WB && bus.mem_resp && beat_cnt_q == LAST) perf_wbs_q <= perf_wbs_q + 32'd1;
      end
   end

   assign perf_fills = perf_fills_q;
   assign perf_wbs   = perf_wbs_q;
`endif

   assign bus.done       = done_q;
   assign bus.arr_we     = arr_we_q;
   assign bus.arr_windex = arr_windex_q;
   assign bus.arr_datain = line_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = (state_q == WB) ? line_q[beat_cnt_q] : '0;
   assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_l2_burst_adapter.sv
// Directed + randomized bench for l2_burst_adapter with a transaction-level memory/array model.
// Build with L2_BURST_PERF_EN defined to also check the performance counters.
module tb_l2_burst_adapter;
   localparam int S_OFFSET = 5;
   localparam int S_INDEX  = 3;
   localparam int BEAT_W   = 64;
   localparam int LINE_W   = 256;
   localparam int BEATS    = 4;

   logic       clk;
   logic       rst_n;
   logic [2:0] dbg_state;
`ifdef L2_BURST_PERF_EN
   logic [31:0] perf_fills;
   logic [31:0] perf_wbs;
`endif

   l2_burst_adapter_if #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX), .BEAT_W(BEAT_W)) bus ();

   l2_burst_adapter #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX), .BEAT_W(BEAT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
`ifdef L2_BURST_PERF_EN
      .perf_fills  (perf_fills),
      .perf_wbs    (perf_wbs),
`endif
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int n_vec;
   int n_err;
   int exp_fills;
   int exp_wbs;
   logic [BEAT_W-1:0] rd_beat [BEATS];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [BEAT_W-1:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   // Request inputs random while a transaction is in flight: they must have no effect.
   task automatic scramble();
      bus.fill_req  = 1'($urandom_range(1, 0));
      bus.wb_req    = 1'($urandom_range(1, 0));
      bus.fill_addr = $urandom;
      bus.wb_addr   = $urandom;
      bus.wb_line   = rand_line();
   endtask

   task automatic quiet();
      scramble();
      bus.fill_req = 1'b0;
      bus.wb_req   = 1'b0;
   endtask

   task automatic chk_burst(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [BEAT_W-1:0] wdata);
      chk({tag, ".mem_read"}, LINE_W'(bus.mem_read), LINE_W'(rd));
      chk({tag, ".mem_write"}, LINE_W'(bus.mem_write), LINE_W'(wr));
      chk({tag, ".mem_addr"}, LINE_W'(bus.mem_addr), LINE_W'(addr));
      if (wr) chk({tag, ".mem_wdata"}, LINE_W'(bus.mem_wdata), LINE_W'(wdata));
      chk({tag, ".arr_we"}, LINE_W'(bus.arr_we), '0);
      chk({tag, ".done"}, LINE_W'(bus.done), '0);
   endtask

   // One complete transaction; the model is the rule set: beats in order, LSB-first packing,
   // writeback before fill, a single commit and a single done pulse.
   task automatic run_txn(input bit do_fill, input bit do_wb, input logic [31:0] faddr,
                          input logic [31:0] waddr, input logic [LINE_W-1:0] wline, input int max_gap);
      logic [31:0]       fa;
      logic [31:0]       wa;
      logic [LINE_W-1:0] exp_line;
      int                gap;
      fa = faddr & 32'hFFFF_FFE0;
      wa = waddr & 32'hFFFF_FFE0;
      for (int i = 0; i < BEATS; i++) exp_line[i*BEAT_W +: BEAT_W] = rd_beat[i];
      bus.fill_req  = do_fill;
      bus.wb_req    = do_wb;
      bus.fill_addr = faddr;
      bus.wb_addr   = waddr;
      bus.wb_line   = wline;
      bus.mem_resp  = 1'b0;
      step();
      scramble();
      if (do_wb) begin
         for (int i = 0; i < BEATS; i++) begin
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g <= gap; g++) begin
               bus.mem_resp  = (g == gap);
               bus.mem_rdata = rand64();
               chk_burst($sformatf("wb_beat%0d", i), 1'b0, 1'b1, wa, wline[i*BEAT_W +: BEAT_W]);
               step();
               scramble();
            end
         end
         bus.mem_resp = 1'b0;
         exp_wbs++;
      end
      if (do_fill) begin
         for (int i = 0; i < BEATS; i++) begin
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g <= gap; g++) begin
               bus.mem_resp  = (g == gap);
               bus.mem_rdata = (g == gap) ? rd_beat[i] : rand64();
               chk_burst($sformatf("rd_beat%0d", i), 1'b1, 1'b0, fa, '0);
               step();
               scramble();
            end
         end
         bus.mem_resp  = 1'($urandom_range(1, 0));
         bus.mem_rdata = rand64();
         chk("commit.arr_we", LINE_W'(bus.arr_we), LINE_W'(32'hFFFF_FFFF));
         chk("commit.arr_windex", LINE_W'(bus.arr_windex), LINE_W'(faddr[S_OFFSET+S_INDEX-1:S_OFFSET]));
         chk("commit.arr_datain", bus.arr_datain, exp_line);
         chk("commit.mem_rw", LINE_W'({bus.mem_read, bus.mem_write}), '0);
         chk("commit.done", LINE_W'(bus.done), '0);
         exp_fills++;
         step();
         scramble();
         chk("done.arr_we", LINE_W'(bus.arr_we), '0);
      end
      bus.mem_resp  = 1'($urandom_range(1, 0));
      bus.mem_rdata = rand64();
      chk("done.pulse", LINE_W'(bus.done), LINE_W'(1'b1));
      chk("done.mem_rw", LINE_W'({bus.mem_read, bus.mem_write}), '0);
      step();
      quiet();
      chk("idle.done", LINE_W'(bus.done), '0);
      step();
      bus.mem_resp = 1'b0;
      chk("idle.no_accept", LINE_W'({bus.done, bus.mem_read, bus.mem_write}), '0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".done"}, LINE_W'(bus.done), '0);
      chk({tag, ".arr_we"}, LINE_W'(bus.arr_we), '0);
      chk({tag, ".arr_windex"}, LINE_W'(bus.arr_windex), '0);
      chk({tag, ".arr_datain"}, bus.arr_datain, '0);
      chk({tag, ".mem_rw"}, LINE_W'({bus.mem_read, bus.mem_write}), '0);
      chk({tag, ".mem_addr"}, LINE_W'(bus.mem_addr), '0);
      chk({tag, ".mem_wdata"}, LINE_W'(bus.mem_wdata), '0);
   endtask

   initial begin
      logic [LINE_W-1:0] pat;
      int kind;
      clk       = 1'b0;
      rst_n     = 1'b0;
      n_vec     = 0;
      n_err     = 0;
      exp_fills = 0;
      exp_wbs   = 0;
      quiet();
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Directed fill, no stalls
      rd_beat[0] = 64'h1111_1111_1111_1111;
      rd_beat[1] = 64'h2222_2222_2222_2222;
      rd_beat[2] = 64'h3333_3333_3333_3333;
      rd_beat[3] = 64'h4444_4444_4444_4444;
      run_txn(1'b1, 1'b0, 32'h0000_1064, 32'h0, '0, 0);

      // Directed writeback of a byte-ramp line
      for (int k = 0; k < LINE_W / 8; k++) pat[k*8 +: 8] = 8'(k);
      run_txn(1'b0, 1'b1, 32'h0, 32'h0000_2040, pat, 0);

      // Combined writeback then fill
      for (int i = 0; i < BEATS; i++) rd_beat[i] = rand64();
      run_txn(1'b1, 1'b1, 32'h0000_30A0, 32'h0000_4000, rand_line(), 0);

      // Randomized transactions with 0-5 cycle response gaps
      for (int t = 0; t < 16; t++) begin
         kind = $urandom_range(2, 0);
         for (int i = 0; i < BEATS; i++) rd_beat[i] = rand64();
         run_txn(kind != 1, kind != 0, $urandom, $urandom, rand_line(), 5);
      end

      // Asynchronous reset after two beats of a fill
      for (int i = 0; i < BEATS; i++) rd_beat[i] = rand64();
      bus.fill_req  = 1'b1;
      bus.fill_addr = 32'h0000_5080;
      step();
      quiet();
      for (int i = 0; i < 2; i++) begin
         bus.mem_resp  = 1'b1;
         bus.mem_rdata = rd_beat[i];
         step();
      end
      bus.mem_resp = 1'b0;
      chk("pre_reset.mem_read", LINE_W'(bus.mem_read), LINE_W'(1'b1));
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      exp_fills = 0;
      exp_wbs   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < BEATS; i++) rd_beat[i] = rand64();
      run_txn(1'b1, 1'b0, 32'h0000_5080, 32'h0, '0, 2);

      // Two more fills and two combined requests after the reset
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < BEATS; i++) rd_beat[i] = rand64();
         run_txn(1'b1, t >= 2, $urandom, $urandom, rand_line(), 3);
      end

`ifdef L2_BURST_PERF_EN
      chk("perf_fills", LINE_W'(perf_fills), LINE_W'(exp_fills));
      chk("perf_wbs", LINE_W'(perf_wbs), LINE_W'(exp_wbs));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
